tmds_rx_decoder: RTL

Receive-side counterpart of the GTH TMDS serializer. Takes three lanes of raw 10-bit GT RX symbols (red, green, blue) in the 148.5 MHz `txoutclk_internal` domain. For each lane it finds the symbol boundary by searching for TMDS control tokens, then decodes the symbols back to 8-bit pixel data plus sync and control bits. It sits between the RX gearbox (60-bit, 74.25 MHz to 10-bit per lane, 148.5 MHz) and the pixel sink, and reports lock status to the link monitor.

---
 rtl/tmds_rx_decoder_pkg.sv | 43 ++++
 rtl/tmds_rx_decoder_if.sv | 41 ++++
 rtl/tmds_rx_decoder_lane_align_decode.sv | 100 ++++++++++
 rtl/tmds_rx_decoder.sv | 98 +++++++++
 4 files changed

// File: rtl/tmds_rx_decoder_pkg.sv
// TMDS receive decoder shared definitions.
// Control tokens, lane state and symbol decode helpers.
package tmds_pkg;

  localparam logic [9:0] TOK_00 = 10'h354;
  localparam logic [9:0] TOK_01 = 10'h0AB;
  localparam logic [9:0] TOK_10 = 10'h154;
  localparam logic [9:0] TOK_11 = 10'h2AB;

  typedef enum logic {
    SEARCH,
    LOCKED
  } lane_state_t;

  function automatic logic [7:0] tmds_decode8(
    input logic [9:0] sym
  );
    logic [7:0] d;
    logic [7:0] q;
    d = sym[9] ? ~sym[7:0] : sym[7:0];
    q[0] = d[0];
    for (int i = 1; i < 8; i++)
      q[i] = sym[8] ? (d[i] ^ d[i-1])
                    : ~(d[i] ^ d[i-1]);
    return q;
  endfunction

  // returns {is_token, c1, c0}
  function automatic logic [2:0] tmds_ctl_lookup(
    input logic [9:0] sym
  );
    logic [2:0] r;
    case (sym)
      TOK_00:  r = 3'b100;
      TOK_01:  r = 3'b101;
      TOK_10:  r = 3'b110;
      TOK_11:  r = 3'b111;
      default: r = 3'b000;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/tmds_rx_decoder_if.sv
// Raw lane input and decoded pixel output bundle
// between the RX gearbox, decoder and pixel sink.
interface tmds_rx_decoder_if;
  import tmds_pkg::*;

  logic       in_valid;
  logic [9:0] raw_r;
  logic [9:0] raw_g;
  logic [9:0] raw_b;

  logic       out_valid;
  logic [7:0] red;
  logic [7:0] green;
  logic [7:0] blue;
  logic       de;
  logic       hsync;
  logic       vsync;
  logic [3:0] ctl;
  logic [2:0] lane_locked;
  logic       locked;
  logic [3:0] slip_r;
  logic [3:0] slip_g;
  logic [3:0] slip_b;

  modport master (
    output in_valid, raw_r, raw_g, raw_b,
    input  out_valid, red, green, blue,
    input  de, hsync, vsync, ctl,
    input  lane_locked, locked,
    input  slip_r, slip_g, slip_b
  );

  modport slave (
    input  in_valid, raw_r, raw_g, raw_b,
    output out_valid, red, green, blue,
    output de, hsync, vsync, ctl,
    output lane_locked, locked,
    output slip_r, slip_g, slip_b
  );

endinterface

// File: rtl/tmds_rx_decoder_lane_align_decode.sv
// One TMDS lane: bit-slip search on control tokens,
// lock tracking and two-stage symbol decode.
module tmds_lane_align_decode
  import tmds_pkg::*;
#(
  parameter int LOCK_TOKENS   = 64,
  parameter int SEARCH_WINDOW = 2048,
  parameter int MAX_GAP       = 4096
) (
  input  logic       txoutclk_internal,
  input  logic       reset,
  input  logic       in_valid,
  input  logic [9:0] raw,
  input  logic       data_en,
  output logic       tok1,
  output logic [7:0] pix,
  output logic [1:0] c,
  output logic       lane_locked,
  output logic [3:0] slip
);

  localparam int TW = $clog2(LOCK_TOKENS) + 1;
  localparam int WW = $clog2(SEARCH_WINDOW) + 1;
  localparam int GW = $clog2(MAX_GAP) + 1;

  lane_state_t state;

  logic [9:0]    prev;
  logic [19:0]   win;
  logic [9:0]    sym;
  logic [9:0]    sym1;
  logic [2:0]    look;
  logic [2:0]    look1;
  logic          hit;
  logic [TW-1:0] tok_cnt;
  logic [WW-1:0] win_cnt;
  logic [GW-1:0] gap_cnt;

  assign win  = {raw, prev};
  assign sym  = 10'(win >> slip);
  assign look = tmds_ctl_lookup(sym);
  assign hit  = look[2];
  assign look1 = tmds_ctl_lookup(sym1);

  assign lane_locked = (state == LOCKED);

  always_ff @(posedge txoutclk_internal) begin
    if (reset) begin
      state   <= SEARCH;
      prev    <= '0;
      sym1    <= '0;
      tok1    <= 1'b0;
      pix     <= '0;
      c       <= '0;
      slip    <= '0;
      tok_cnt <= '0;
      win_cnt <= '0;
      gap_cnt <= '0;
    end else if (in_valid) begin
      prev <= raw;
      sym1 <= sym;
      tok1 <= hit;
      // data_en follows the blue lane's stage-1 symbol
      if (data_en)
        pix <= tmds_decode8(sym1);
      else if (look1[2])
        c <= look1[1:0];
      unique case (state)
        SEARCH: begin
          if (hit && tok_cnt == TW'(LOCK_TOKENS - 1)) begin
            state   <= LOCKED;
            tok_cnt <= '0;
            win_cnt <= '0;
            gap_cnt <= '0;
          end else if (win_cnt == WW'(SEARCH_WINDOW - 1)) begin
            slip    <= (slip == 4'd9) ? 4'd0 : slip + 4'd1;
            tok_cnt <= '0;
            win_cnt <= '0;
          end else begin
            win_cnt <= win_cnt + WW'(1);
            tok_cnt <= tok_cnt + TW'(hit);
          end
        end
        LOCKED: begin
          if (hit) begin
            gap_cnt <= '0;
          end else if (gap_cnt == GW'(MAX_GAP - 1)) begin
            state   <= SEARCH;
            tok_cnt <= '0;
            win_cnt <= '0;
            gap_cnt <= '0;
          end else begin
            gap_cnt <= gap_cnt + GW'(1);
          end
        end
      endcase
    end
  end

endmodule

// File: rtl/tmds_rx_decoder.sv
// Three-lane TMDS receive decoder: per-lane alignment,
// lane lock combine and sync/control mapping.
module tmds_rx_decoder
  import tmds_pkg::*;
#(
  parameter int LOCK_TOKENS   = 64,
  parameter int SEARCH_WINDOW = 2048,
  parameter int MAX_GAP       = 4096
) (
  input logic               txoutclk_internal,
  input logic               reset,
  tmds_rx_decoder_if.slave  bus
);

  logic       tok1_r, tok1_g, tok1_b;
  logic       lk_r, lk_g, lk_b;
  logic [1:0] c_r, c_g, c_b;
  logic       data_en;
  logic       de_q;
  logic       acc_q;

  assign data_en = ~tok1_b;

  tmds_lane_align_decode #(
    .LOCK_TOKENS  (LOCK_TOKENS),
    .SEARCH_WINDOW(SEARCH_WINDOW),
    .MAX_GAP      (MAX_GAP)
  ) u_lane_r (
    .txoutclk_internal(txoutclk_internal),
    .reset      (reset),
    .in_valid   (bus.in_valid),
    .raw        (bus.raw_r),
    .data_en    (data_en),
    .tok1       (tok1_r),
    .pix        (bus.red),
    .c          (c_r),
    .lane_locked(lk_r),
    .slip       (bus.slip_r)
  );

  tmds_lane_align_decode #(
    .LOCK_TOKENS  (LOCK_TOKENS),
    .SEARCH_WINDOW(SEARCH_WINDOW),
    .MAX_GAP      (MAX_GAP)
  ) u_lane_g (
    .txoutclk_internal(txoutclk_internal),
    .reset      (reset),
    .in_valid   (bus.in_valid),
    .raw        (bus.raw_g),
    .data_en    (data_en),
    .tok1       (tok1_g),
    .pix        (bus.green),
    .c          (c_g),
    .lane_locked(lk_g),
    .slip       (bus.slip_g)
  );

  tmds_lane_align_decode #(
    .LOCK_TOKENS  (LOCK_TOKENS),
    .SEARCH_WINDOW(SEARCH_WINDOW),
    .MAX_GAP      (MAX_GAP)
  ) u_lane_b (
    .txoutclk_internal(txoutclk_internal),
    .reset      (reset),
    .in_valid   (bus.in_valid),
    .raw        (bus.raw_b),
    .data_en    (data_en),
    .tok1       (tok1_b),
    .pix        (bus.blue),
    .c          (c_b),
    .lane_locked(lk_b),
    .slip       (bus.slip_b)
  );

  always_ff @(posedge txoutclk_internal) begin
    if (reset) begin
      de_q  <= 1'b0;
      acc_q <= 1'b0;
    end else begin
      acc_q <= bus.in_valid;
      if (bus.in_valid)
        de_q <= data_en;
    end
  end

  // red/green token flags only steer their own ctl hold
  logic unused_tok;
  assign unused_tok = tok1_r ^ tok1_g;

  assign bus.de          = de_q;
  assign bus.hsync       = c_b[0];
  assign bus.vsync       = c_b[1];
  assign bus.ctl         = {c_r, c_g};
  assign bus.lane_locked = {lk_b, lk_g, lk_r};
  assign bus.locked      = lk_r & lk_g & lk_b;
  assign bus.out_valid   = acc_q & bus.locked;

endmodule
